// File: rtl/jk_arb_pkg.sv
// Shared types and constants for the JK bank arbiter: FSM states, JK command codes, defaults.
package jk_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK bit of the shared bank, async cleared to 0.
// Latency: q follows {j,k} one edge after en; no backpressure (en is a pure qualifier).
// Flow control: none, the arbiter decides when en is high.
module jk_cell
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one requester a JK update of a shared bank; JKARB_LOCK_EN adds lock bursts.
// Latency: req sampled at n, gnt at n+1, q/done at n+2, next arbitration at n+3.
// Backpressure: requester holds req until granted; dropping req while granted aborts the op.
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
`ifdef JKARB_LOCK_EN
  , parameter int LOCK_MAX = 4
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] cmd_j,
  input  logic [N_REQ*WIDTH-1:0] cmd_k,
`ifdef JKARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qbar,
  output logic                   done
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   rr_next;
  logic            found;
  int              idx;
  logic            apply_en;
  logic [WIDTH-1:0] win_j;
  logic [WIDTH-1:0] win_k;

`ifdef JKARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] burst;
`endif

  // First active request at or after rr_ptr, scanning cyclically.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign rr_next  = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
  assign win_j    = cmd_j[int'(win)*WIDTH +: WIDTH];
  assign win_k    = cmd_k[int'(win)*WIDTH +: WIDTH];
  assign apply_en = (state == GRANT) && req[win];
  assign qbar     = ~q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= 1'b0;
      rr_ptr <= '0;
      win    <= '0;
`ifdef JKARB_LOCK_EN
      burst  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (|req) begin
            win    <= pick;
            gnt    <= ONE << pick;
            rr_ptr <= rr_next;
            state  <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (req[win]) begin
            done  <= 1'b1;
            state <= APPLY;
`ifdef JKARB_LOCK_EN
            burst <= burst + CW'(1);
`endif
          end else begin
            state <= IDLE;
`ifdef JKARB_LOCK_EN
            burst <= '0;
`endif
          end
        end
        APPLY: begin
          done <= 1'b0;
`ifdef JKARB_LOCK_EN
          // A locked winner keeps the bank without re-arbitration until the burst cap.
          if (lock[win] && req[win] && (burst < CW'(LOCK_MAX))) begin
            gnt   <= ONE << win;
            state <= GRANT;
          end else begin
            burst <= '0;
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (win_j[b]),
      .k   (win_k[b]),
      .en  (apply_en),
      .q   (q[b])
    );
  end

endmodule
